// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: WIDTH x WIDTH -> 2*WIDTH product, signed or unsigned,
// with WIDTH+1 iterations per operation, a start/busy/done handshake and a synchronous abort.
module booth_mult_seq #(
  parameter  int WIDTH = 16,
  localparam int CW    = $clog2(WIDTH + 2)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state, state_nxt;
  logic signed [WIDTH+1:0]  acc, acc_nxt;
  logic        [WIDTH:0]    mq, mq_nxt;
  logic signed [WIDTH:0]    mcand, mcand_nxt;
  logic                     q_m1, q_m1_nxt;
  logic        [CW-1:0]     count, count_nxt;
  logic                     busy_nxt, done_nxt;
  logic        [2*WIDTH-1:0] product_nxt;
  logic signed [WIDTH+1:0]  mcand_x;
  logic signed [WIDTH+1:0]  sum;

  // One extra bit lets unsigned operands with the MSB set be treated as positive signed values.
  function automatic logic [WIDTH:0] extend(input logic [WIDTH-1:0] v, input logic sgn);
    return {sgn & v[WIDTH-1], v};
  endfunction

  assign mcand_x = {mcand[WIDTH], mcand};

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    mq_nxt      = mq;
    mcand_nxt   = mcand;
    q_m1_nxt    = q_m1;
    count_nxt   = count;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    product_nxt = product;
    sum         = acc;
    unique case (state)
      IDLE: begin
        if (start) begin
          mcand_nxt = extend(multiplicand, is_signed);
          mq_nxt    = extend(multiplier, is_signed);
          acc_nxt   = '0;
          q_m1_nxt  = 1'b0;
          count_nxt = CW'(WIDTH + 1);
          busy_nxt  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          unique case ({mq[0], q_m1})
            2'b10:   sum = acc - mcand_x;
            2'b01:   sum = acc + mcand_x;
            default: sum = acc;
          endcase
          // Arithmetic shift of {sum, mq, q_m1} right by one.
          acc_nxt   = {sum[WIDTH+1], sum[WIDTH+1:1]};
          mq_nxt    = {sum[0], mq[WIDTH:1]};
          q_m1_nxt  = mq[0];
          count_nxt = count - CW'(1);
          if (count == CW'(1)) begin
            product_nxt = {acc_nxt[WIDTH-2:0], mq_nxt};
            done_nxt    = 1'b1;
            busy_nxt    = 1'b0;
            state_nxt   = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      acc     <= '0;
      mq      <= '0;
      mcand   <= '0;
      q_m1    <= 1'b0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      mq      <= mq_nxt;
      mcand   <= mcand_nxt;
      q_m1    <= q_m1_nxt;
      count   <= count_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      product <= product_nxt;
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: a WIDTH=16 instance for handshake/corner vectors and a
// WIDTH=4 instance swept exhaustively against a plain multiplication model.
module tb_booth_mult_seq;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, is_signed, abort;
  logic [15:0] multiplicand, multiplier;
  logic        busy, done;
  logic [31:0] product;

  logic        start4, is_signed4, abort4;
  logic [3:0]  mcand4, mplier4;
  logic        busy4, done4;
  logic [7:0]  product4;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  booth_mult_seq #(.WIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .is_signed(is_signed),
    .multiplicand(multiplicand), .multiplier(multiplier), .abort(abort),
    .busy(busy), .done(done), .product(product)
  );

  booth_mult_seq #(.WIDTH(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .start(start4), .is_signed(is_signed4),
    .multiplicand(mcand4), .multiplier(mplier4), .abort(abort4),
    .busy(busy4), .done(done4), .product(product4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge, then scramble the operands so capture timing is exercised.
  task automatic launch16(input logic sgn, input logic [15:0] a, input logic [15:0] b);
    @(negedge clock);
    start = 1'b1; is_signed = sgn; multiplicand = a; multiplier = b;
    @(negedge clock);
    start = 1'b0; is_signed = ~sgn; multiplicand = ~a; multiplier = ~b;
  endtask

  task automatic wait_done16(output int lat);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!done && lat < 40);
  endtask

  task automatic run16(input string tag, input logic sgn, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] exp);
    int lat;
    launch16(sgn, a, b);
    wait_done16(lat);
    chk({tag, "_lat"}, lat, 17);
    chk({tag, "_prod"}, product, exp);
  endtask

  task automatic run4(input string tag, input logic sgn, input logic [3:0] a,
                      input logic [3:0] b, input logic [7:0] exp);
    int lat;
    @(negedge clock);
    start4 = 1'b1; is_signed4 = sgn; mcand4 = a; mplier4 = b;
    @(negedge clock);
    start4 = 1'b0; is_signed4 = ~sgn; mcand4 = ~a; mplier4 = ~b;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!done4 && lat < 20);
    chk({tag, "_lat"}, lat, 5);
    chk({tag, "_prod"}, product4, exp);
  endtask

  initial begin
    int lat, lat2, seen;
    reset_n = 1'b0;
    start = 1'b0; is_signed = 1'b0; abort = 1'b0; multiplicand = '0; multiplier = '0;
    start4 = 1'b0; is_signed4 = 1'b0; abort4 = 1'b0; mcand4 = '0; mplier4 = '0;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_prod", product, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // 3 * -5 with exact busy/done timing
    launch16(1'b1, 16'h0003, 16'hFFFB);
    chk("t1_busy_k", busy, 1'b1);
    repeat (16) @(negedge clock);
    chk("t1_busy_k16", busy, 1'b1);
    chk("t1_done_early", done, 1'b0);
    @(negedge clock);
    chk("t1_busy_k17", busy, 1'b0);
    chk("t1_done", done, 1'b1);
    chk("t1_prod", product, 32'hFFFFFFF1);
    @(negedge clock);
    chk("t1_done_pulse", done, 1'b0);
    chk("t1_prod_hold", product, 32'hFFFFFFF1);

    run16("s_8000x8000", 1'b1, 16'h8000, 16'h8000, 32'h40000000);
    run16("s_8000x0001", 1'b1, 16'h8000, 16'h0001, 32'hFFFF8000);
    run16("s_7fffx8000", 1'b1, 16'h7FFF, 16'h8000, 32'hC0008000);
    run16("u_ffffxffff", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    run16("u_8000x0002", 1'b0, 16'h8000, 16'h0002, 32'h00010000);
    run16("s_ffffxffff", 1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001);

    // start while busy is ignored and not queued
    launch16(1'b0, 16'h1234, 16'h0010);
    repeat (5) @(negedge clock);
    start = 1'b1; is_signed = 1'b1; multiplicand = 16'h7FFF; multiplier = 16'h7FFF;
    @(negedge clock);
    start = 1'b0;
    wait_done16(lat);
    chk("ign_lat", lat + 6, 17);
    chk("ign_prod", product, 32'h00012340);
    @(negedge clock);
    chk("ign_not_queued", busy, 1'b0);

    // start held through the done cycle
    @(negedge clock);
    start = 1'b1; is_signed = 1'b1; multiplicand = 16'h0003; multiplier = 16'hFFFB;
    @(negedge clock);
    is_signed = 1'b0; multiplicand = 16'h0200; multiplier = 16'h0300;
    wait_done16(lat);
    chk("b2b_lat1", lat, 17);
    chk("b2b_prod1", product, 32'hFFFFFFF1);
    wait_done16(lat2);
    start = 1'b0;
    chk("b2b_gap", lat2, 18);
    chk("b2b_prod2", product, 32'h00060000);

    // abort at iteration 8
    launch16(1'b1, 16'h7FFF, 16'h7FFF);
    repeat (8) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    seen = 0;
    repeat (25) begin
      @(negedge clock);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_prod", product, 32'h00060000);

    // abort together with start in IDLE: start wins
    @(negedge clock);
    start = 1'b1; abort = 1'b1; is_signed = 1'b1; multiplicand = 16'h7FFF; multiplier = 16'h7FFF;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    wait_done16(lat);
    chk("abst_lat", lat, 17);
    chk("abst_prod", product, 32'h3FFF0001);

    // asynchronous reset mid-operation
    launch16(1'b0, 16'hFFFF, 16'hFFFF);
    repeat (6) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_prod", product, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clock);
      if (done) seen++;
    end
    chk("arst_no_done", seen, 0);

    // WIDTH=4 exhaustive sweep
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          logic signed [3:0] sa, sb;
          logic [7:0] exp8;
          sa = 4'(a);
          sb = 4'(b);
          exp8 = (s == 1) ? 8'(int'(sa) * int'(sb)) : 8'(a * b);
          run4($sformatf("w4_s%0d_%0h_%0h", s, a, b), 1'(s), 4'(a), 4'(b), exp8);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
